// File: rtl/sram_port_scheduler_if.sv
// Request/grant bundle between the ingress port FIFOs (master) and the SRAM port scheduler (slave).
interface sram_port_scheduler_if #(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned WEIGHT_W  = 4
);
    localparam int unsigned IdW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic                          sp0_wrr1;
    logic [NUM_PORTS-1:0]          req;
    logic [NUM_PORTS-1:0]          last;
    logic [NUM_PORTS*WEIGHT_W-1:0] weight;
    logic [NUM_PORTS-1:0]          gnt;
    logic                          gnt_valid;
    logic [IdW-1:0]                gnt_id;

    modport master (
        output sp0_wrr1, req, last, weight,
        input  gnt, gnt_valid, gnt_id
    );

    modport slave (
        input  sp0_wrr1, req, last, weight,
        output gnt, gnt_valid, gnt_id
    );
endinterface

// File: rtl/sram_port_scheduler.sv
// Packet-level SP / WRR scheduler for the shared SRAM write datapath; grant held until packet end.
// Optional SP aging is built when the SCHED_AGING_EN macro is defined.
module sram_port_scheduler #(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned WEIGHT_W  = 4,
    parameter int unsigned AGE_W     = 4,
    parameter int unsigned AGE_LIMIT = 8
) (
    input logic                  clk,
    input logic                  rst,
    sram_port_scheduler_if.slave bus
);
    localparam int unsigned IdW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    if ((NUM_PORTS < 2) || (AGE_LIMIT > (2 ** AGE_W) - 1)) begin : g_param_check
        $error("sram_port_scheduler: NUM_PORTS must be >= 2 and AGE_LIMIT must fit in AGE_W");
    end

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e               state_q, state_d;
    logic [NUM_PORTS-1:0] gnt_q, gnt_d;
    logic                 gnt_valid_q, gnt_valid_d;
    logic [IdW-1:0]       gnt_id_q, gnt_id_d;
    logic [IdW-1:0]       rr_ptr_q, rr_ptr_d;
    logic                 prev_mode_q, prev_mode_d;
    logic [WEIGHT_W-1:0]  credit_q   [NUM_PORTS];
    logic [WEIGHT_W-1:0]  credit_d   [NUM_PORTS];
    logic [WEIGHT_W-1:0]  credit_eff [NUM_PORTS];

    logic                 mode;
    logic                 granted_req, granted_last, release_gnt, decide;
    logic [NUM_PORTS-1:0] excl, cand;
    logic [NUM_PORTS-1:0] sp_pool;
    logic                 sp_found;
    logic [IdW-1:0]       sp_win;
    logic [NUM_PORTS-1:0] cur_elig, own_elig, wrr_pool;
    logic                 reload, wrr_found;
    logic [IdW-1:0]       wrr_win, scan_idx;
    logic                 win_found;
    logic [IdW-1:0]       win_id;

    assign mode = bus.sp0_wrr1;

    // The releasing port is excluded so the datapath moves on to another requester.
    always_comb begin
        granted_req  = |(bus.req & gnt_q);
        granted_last = |(bus.last & gnt_q);
        release_gnt  = (state_q == StGrant) && (!granted_req || granted_last);
        decide       = (state_q == StIdle) || release_gnt;
        excl         = release_gnt ? gnt_q : '0;
        cand         = bus.req & ~excl;
    end

`ifdef SCHED_AGING_EN
    logic [AGE_W-1:0]     age_q [NUM_PORTS];
    logic [AGE_W-1:0]     age_d [NUM_PORTS];
    logic [NUM_PORTS-1:0] aged;

    always_comb begin
        for (int i = 0; i < int'(NUM_PORTS); i++) begin
            aged[i]  = (age_q[i] == AGE_W'(AGE_LIMIT));
            age_d[i] = age_q[i];
            if (mode || !bus.req[i] || gnt_q[i]) begin
                age_d[i] = '0;
            end else if (!aged[i]) begin
                age_d[i] = age_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_PORTS); i++) age_q[i] <= '0;
        end else begin
            age_q <= age_d;
        end
    end
`endif

    always_comb begin
        sp_pool = cand;
`ifdef SCHED_AGING_EN
        if (|(cand & aged)) sp_pool = cand & aged;
`endif
        sp_found = |sp_pool;
        sp_win   = '0;
        for (int i = int'(NUM_PORTS) - 1; i >= 0; i--) begin
            if (sp_pool[i]) sp_win = IdW'(i);
        end
    end

    // A releasing port still holding credit keeps the datapath only when no other requester has
    // credit; otherwise an empty pool triggers a reload.
    always_comb begin
        for (int i = 0; i < int'(NUM_PORTS); i++) begin
            cur_elig[i] = cand[i] && (credit_q[i] != '0);
            own_elig[i] = bus.req[i] && excl[i] && (credit_q[i] != '0);
        end
        reload = mode && (|cand) && (!prev_mode_q || (!(|cur_elig) && !(|own_elig)));
        for (int i = 0; i < int'(NUM_PORTS); i++) begin
            credit_eff[i] = credit_q[i];
            if (reload) begin
                credit_eff[i] = (bus.weight[i*WEIGHT_W +: WEIGHT_W] == '0) ?
                                WEIGHT_W'(1) : bus.weight[i*WEIGHT_W +: WEIGHT_W];
            end
            wrr_pool[i] = cand[i] && (credit_eff[i] != '0);
        end
        if (wrr_pool == '0) wrr_pool = own_elig;
        wrr_found = 1'b0;
        wrr_win   = '0;
        scan_idx  = '0;
        for (int k = 0; k < int'(NUM_PORTS); k++) begin
            scan_idx = IdW'((int'(rr_ptr_q) + k) % int'(NUM_PORTS));
            if (!wrr_found && wrr_pool[scan_idx]) begin
                wrr_found = 1'b1;
                wrr_win   = scan_idx;
            end
        end
    end

    assign win_found = mode ? wrr_found : sp_found;
    assign win_id    = mode ? wrr_win : sp_win;

    always_ff @(posedge clk) begin : state_reg
        if (rst) begin
            state_q     <= StIdle;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            gnt_id_q    <= '0;
            rr_ptr_q    <= '0;
            prev_mode_q <= 1'b0;
            for (int i = 0; i < int'(NUM_PORTS); i++) credit_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
            gnt_id_q    <= gnt_id_d;
            rr_ptr_q    <= rr_ptr_d;
            prev_mode_q <= prev_mode_d;
            credit_q    <= credit_d;
        end
    end

    always_comb begin : next_state
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (win_found) state_d = StGrant;
            StGrant: if (release_gnt) state_d = win_found ? StGrant : StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin : next_outputs
        gnt_d       = gnt_q;
        gnt_valid_d = gnt_valid_q;
        gnt_id_d    = gnt_id_q;
        rr_ptr_d    = rr_ptr_q;
        prev_mode_d = prev_mode_q;
        credit_d    = credit_q;
        if (decide) begin
            if (win_found) begin
                gnt_d         = '0;
                gnt_d[win_id] = 1'b1;
                gnt_valid_d   = 1'b1;
                gnt_id_d      = win_id;
                prev_mode_d   = mode;
                if (mode) begin
                    credit_d         = credit_eff;
                    credit_d[win_id] = credit_eff[win_id] - 1'b1;
                    rr_ptr_d         = (win_id == IdW'(NUM_PORTS - 1)) ? '0 : win_id + 1'b1;
                end
            end else begin
                gnt_d       = '0;
                gnt_valid_d = 1'b0;
            end
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_valid = gnt_valid_q;
    assign bus.gnt_id    = gnt_id_q;
endmodule

// File: tb/tb_sram_port_scheduler.sv
// Directed bench for sram_port_scheduler: a simple per-port packet source drives req/last and
// grants are compared against hand-derived sequences.
`timescale 1ns/1ps
module tb_sram_port_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sram_port_scheduler_if #(.NUM_PORTS(4), .WEIGHT_W(4)) bus ();

    sram_port_scheduler #(
        .NUM_PORTS(4),
        .WEIGHT_W (4),
        .AGE_W    (4),
        .AGE_LIMIT(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int   checks = 0;
    int   errors = 0;
    int   pkts [4];
    int   plen [4];
    int   beat [4];
    logic pend_beat [4];
    logic pend_last [4];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present req/last for the current cycle; remember what the DUT will consume at the next edge.
    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            bus.req[i]   = (pkts[i] > 0);
            bus.last[i]  = bus.req[i] & bus.gnt[i] & (beat[i] == plen[i] - 1);
            pend_beat[i] = bus.req[i] & bus.gnt[i];
            pend_last[i] = bus.last[i];
        end
    endtask

    task automatic step();
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            if (pend_beat[i]) begin
                if (pend_last[i]) begin
                    beat[i] = 0;
                    pkts[i]--;
                end else begin
                    beat[i]++;
                end
            end
        end
        drive();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            pkts[i]      = 0;
            beat[i]      = 0;
            plen[i]      = 1;
            pend_beat[i] = 1'b0;
            pend_last[i] = 1'b0;
        end
        drive();
        repeat (2) step();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_wrr [10] = '{0, 1, 2, 3, 1, 2, 3, 0, 1, 1};
        int exp_mode [7] = '{0, 0, 0, 1, 2, 3, 0};
        logic [3:0] one;
        int first;
        int p3_cnt;

        bus.sp0_wrr1 = 1'b0;
        bus.weight   = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            pkts[i] = 1; plen[i] = 1; beat[i] = 0; pend_beat[i] = 1'b0; pend_last[i] = 1'b0;
        end

        // Reset held 3 cycles with all ports requesting.
        drive();
        for (int c = 0; c < 3; c++) begin
            step();
            check_eq($sformatf("rst_gnt_%0d", c), 32'(bus.gnt), 32'h0);
            check_eq($sformatf("rst_valid_%0d", c), 32'(bus.gnt_valid), 32'h0);
            check_eq($sformatf("rst_id_%0d", c), 32'(bus.gnt_id), 32'h0);
        end
        rst = 1'b0;
        check_eq("rst_release_gnt", 32'(bus.gnt), 32'h0);
        step();
        check_eq("first_gnt", 32'(bus.gnt), 32'h1);
        check_eq("first_valid", 32'(bus.gnt_valid), 32'h1);

        // SP, ports 1 and 3 with one 2-beat packet each.
        do_reset();
        pkts[1] = 1; pkts[3] = 1;
        for (int i = 0; i < 4; i++) plen[i] = 2;
        drive();
        step(); check_eq("sp_t1", 32'(bus.gnt), 32'b0010);
        step(); check_eq("sp_t2", 32'(bus.gnt), 32'b0010);
        step(); check_eq("sp_t3", 32'(bus.gnt), 32'b1000);
        check_eq("sp_t3_id", 32'(bus.gnt_id), 32'd3);
        step(); check_eq("sp_t4", 32'(bus.gnt), 32'b1000);
        step(); check_eq("sp_t5", 32'(bus.gnt), 32'b0000);
        check_eq("sp_t5_valid", 32'(bus.gnt_valid), 32'h0);
        check_eq("sp_t5_id_hold", 32'(bus.gnt_id), 32'd3);

        // WRR, weights {p3..p0} = {1,0,2,1}, all ports back-to-back 1-beat packets.
        do_reset();
        bus.sp0_wrr1 = 1'b1;
        bus.weight   = 16'h1021;
        for (int i = 0; i < 4; i++) pkts[i] = 1000;
        drive();
        for (int n = 0; n < 10; n++) begin
            step();
            one = 4'b0001 << exp_wrr[n];
            check_eq($sformatf("wrr_id_%0d", n), 32'(bus.gnt_id), 32'(exp_wrr[n]));
            check_eq($sformatf("wrr_gnt_%0d", n), 32'(bus.gnt), 32'(one));
        end

        // Abort: port2 drops req without last while port0 waits.
        do_reset();
        bus.sp0_wrr1 = 1'b0;
        for (int i = 0; i < 4; i++) plen[i] = 8;
        pkts[2] = 1;
        drive();
        step(); check_eq("abort_p2_gnt", 32'(bus.gnt), 32'b0100);
        pkts[0] = 1; drive();
        step(); check_eq("no_preempt", 32'(bus.gnt), 32'b0100);
        pkts[2] = 0; drive();
        step(); check_eq("abort_p0_gnt", 32'(bus.gnt), 32'b0001);
        check_eq("abort_p0_id", 32'(bus.gnt_id), 32'd0);
        pkts[0] = 0; drive();
        step(); check_eq("abort_idle", 32'(bus.gnt), 32'b0000);

        // Mode switch to WRR in the middle of port0's 3-beat packet.
        do_reset();
        bus.sp0_wrr1 = 1'b0;
        bus.weight   = 16'h1021;
        for (int i = 0; i < 4; i++) begin pkts[i] = 1000; plen[i] = 1; end
        plen[0] = 3;
        drive();
        for (int n = 0; n < 7; n++) begin
            step();
            if (n == 0) bus.sp0_wrr1 = 1'b1;
            check_eq($sformatf("mode_id_%0d", n), 32'(bus.gnt_id), 32'(exp_mode[n]));
        end

        // SP with ports 0 and 1 streaming 1-beat packets while port3 waits.
        do_reset();
        bus.sp0_wrr1 = 1'b0;
        pkts[0] = 1000; pkts[1] = 1000; pkts[3] = 1000;
        drive();
        first  = 0;
        p3_cnt = 0;
`ifdef SCHED_AGING_EN
        for (int c = 1; c <= 12; c++) begin
            step();
            if (bus.gnt[3] && first == 0) first = c;
        end
        check_eq("aging_p3_within_10", 32'((first >= 1) && (first <= 10)), 32'h1);
`else
        for (int c = 1; c <= 100; c++) begin
            step();
            if (bus.gnt[3]) p3_cnt++;
        end
        check_eq("no_aging_p3_starved", 32'(p3_cnt), 32'h0);
`endif

        // Reset in the middle of a packet drops the grant on the next cycle.
        do_reset();
        for (int i = 0; i < 4; i++) plen[i] = 8;
        pkts[2] = 1;
        drive();
        step(); check_eq("midrst_gnt_before", 32'(bus.gnt), 32'b0100);
        rst = 1'b1;
        step(); check_eq("midrst_gnt_after", 32'(bus.gnt), 32'b0000);
        check_eq("midrst_valid_after", 32'(bus.gnt_valid), 32'h0);
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
